// File: rtl/sub_nibble_serial.sv
// Serial subtractor: diff = a - b - bin, one 4-bit borrow-lookahead nibble per clock, LSB first.
// Start/busy/done handshake; borrow, signed-overflow and zero flags are loaded on the last nibble.
module sub_nibble_serial #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);
   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;
   logic [CW-1:0]    r_cnt;
   logic             r_bout;
   logic             r_ovf;
   logic             r_zero;

   logic             w_accept;
   logic             w_last;
   logic [3:0]       w_an;
   logic [3:0]       w_bn;
   logic [3:0]       w_g;
   logic [3:0]       w_p;
   logic [3:0]       w_bw;
   logic             w_bo;
   logic [3:0]       w_d;
   logic [WIDTH-1:0] w_diff_full;

   // DONE accepts a new request just like IDLE, giving back-to-back operation.
   assign w_accept = start && (r_state != S_RUN);
   assign w_last   = (r_cnt == CW'(NIB - 1));

   assign w_an = r_a[{r_cnt, 2'b00} +: 4];
   assign w_bn = r_b[{r_cnt, 2'b00} +: 4];
   assign w_g  = ~w_an & w_bn;
   assign w_p  = ~(w_an ^ w_bn);

   // Borrow lookahead across the slice, seeded by the borrow carried from the previous nibble.
   assign w_bw[0] = r_borrow;
   assign w_bw[1] = w_g[0] | (w_p[0] & r_borrow);
   assign w_bw[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_borrow);
   assign w_bw[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & r_borrow);
   assign w_bo    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_borrow);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dbit
         assign w_d[gi] = w_an[gi] ^ w_bn[gi] ^ w_bw[gi];
      end
   endgenerate

   always_comb begin
      w_diff_full = r_diff;
      w_diff_full[{r_cnt, 2'b00} +: 4] = w_d;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_RUN;
         S_RUN:   if (w_last) w_state_next = S_DONE;
         S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         r_bout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
      end else if (w_accept) begin
         r_a      <= a;
         r_b      <= b;
         r_borrow <= bin;
         r_cnt    <= '0;
         r_diff   <= '0;
      end else if (r_state == S_RUN) begin
         r_diff   <= w_diff_full;
         r_borrow <= w_bo;
         if (!w_last) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_bout <= w_bo;
            r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff_full[WIDTH-1] != r_a[WIDTH-1]);
            r_zero <= (w_diff_full == '0);
         end
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);
   assign diff = r_diff;
   assign bout = r_bout;
   assign ovf  = r_ovf;
   assign zero = r_zero;
endmodule

// File: tb/tb_sub_nibble_serial.sv
// Directed bench for sub_nibble_serial (WIDTH=32): vector table plus handshake corner sequences.
module tb_sub_nibble_serial;
   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        bin;
   logic        busy;
   logic        done;
   logic [31:0] diff;
   logic        bout;
   logic        ovf;
   logic        zero;

   int checks;
   int errors;

   sub_nibble_serial #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        bin;
      logic [31:0] diff;
      logic        bout;
      logic        ovf;
      logic        zero;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Drives one request at a negedge, drops start after the accepting edge, and waits for done.
   // n_done is the negedge count (from the request cycle) at which done was seen, 0 on timeout.
   task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic ibin,
                         output int n_done, output int n_busy);
      n_done = 0;
      n_busy = 0;
      @(negedge clk);
      a = ia; b = ib; bin = ibin; start = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) n_busy++;
         if (done) begin
            n_done = n;
            break;
         end
      end
      if (n_done == 0) begin
         errors++;
         $display("FAIL timeout: no done for a=0x%08h b=0x%08h", ia, ib);
      end
   endtask

   vec_t vecs[8];
   int   nd, nb;

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      vecs[0] = '{32'h5,        32'h3,        1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{32'h0,        32'h1,        1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{32'h80000000, 32'h1,        1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{32'h00001234, 32'h00001234, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{32'h00001234, 32'h00001234, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{32'h12345678, 32'h11111111, 1'b1, 32'h01234566, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset diff", diff, 32'd0);
      chk("reset flags", {29'd0, bout, ovf, zero}, 32'd0);

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].bin, nd, nb);
         $display("op %0d: a=0x%08h b=0x%08h bin=%0b -> diff=0x%08h bout=%0b ovf=%0b zero=%0b (done@%0d busy=%0d)",
                  i, vecs[i].a, vecs[i].b, vecs[i].bin, diff, bout, ovf, zero, nd, nb);
         chk("vec diff", diff, vecs[i].diff);
         chk("vec bout", {31'd0, bout}, {31'd0, vecs[i].bout});
         chk("vec ovf", {31'd0, ovf}, {31'd0, vecs[i].ovf});
         chk("vec zero", {31'd0, zero}, {31'd0, vecs[i].zero});
         chk("vec done latency", nd, 32'd9);
         chk("vec busy cycles", nb, 32'd8);
         @(negedge clk);
         chk("done one cycle", {31'd0, done}, 32'd0);
      end

      // Start pulsed mid-RUN with other operands is ignored; flags hold until the final nibble.
      @(negedge clk);
      a = 32'h0; b = 32'h1; bin = 1'b0; start = 1'b1;
      nd = 0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         start = (n == 3);
         if (n == 3) begin a = 32'h9; b = 32'h9; bin = 1'b1; end
         if (n == 4) chk("flags held mid-run", {29'd0, bout, ovf, zero}, 32'd0);
         if (done) begin nd = n; break; end
      end
      start = 1'b0;
      $display("op ignored-start: diff=0x%08h bout=%0b done@%0d", diff, bout, nd);
      chk("ignored start latency", nd, 32'd9);
      chk("ignored start diff", diff, 32'hFFFFFFFF);
      chk("ignored start bout", {31'd0, bout}, 32'd1);

      // Reset in RUN cycle 5 aborts the operation and clears every output.
      @(negedge clk);
      a = 32'h00ABCDEF; b = 32'h1; bin = 1'b0; start = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("partial diff visible", {31'd0, (diff != 32'd0)}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      $display("op reset-abort: busy=%0b done=%0b diff=0x%08h bout=%0b", busy, done, diff, bout);
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort done", {31'd0, done}, 32'd0);
      chk("abort diff", diff, 32'd0);
      chk("abort flags", {29'd0, bout, ovf, zero}, 32'd0);
      nd = 0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (done || busy) nd++;
      end
      chk("no activity after abort", nd, 32'd0);
      run_op(32'h9, 32'h9, 1'b0, nd, nb);
      $display("op fresh 9-9: diff=0x%08h zero=%0b done@%0d", diff, zero, nd);
      chk("fresh diff", diff, 32'd0);
      chk("fresh zero", {31'd0, zero}, 32'd1);

      // Start held high: three operations back to back, done every 9 cycles.
      @(negedge clk);
      a = 32'd10; b = 32'd4; bin = 1'b0; start = 1'b1;
      begin
         logic [31:0] exp_d[3];
         logic [31:0] nxt_a[3];
         logic [31:0] nxt_b[3];
         int k, last_n;
         exp_d[0] = 32'h6;  exp_d[1] = 32'hFF;  exp_d[2] = 32'hFFFFFFFF;
         nxt_a[0] = 32'h100; nxt_a[1] = 32'd7; nxt_a[2] = 32'd0;
         nxt_b[0] = 32'h1;   nxt_b[1] = 32'd8; nxt_b[2] = 32'd0;
         k = 0;
         last_n = 0;
         for (int n = 1; n <= 60 && k < 3; n++) begin
            @(negedge clk);
            if (done) begin
               $display("op back-to-back %0d: diff=0x%08h after %0d cycles", k, diff, n - last_n);
               chk("b2b interval", n - last_n, 32'd9);
               chk("b2b diff", diff, exp_d[k]);
               last_n = n;
               a = nxt_a[k]; b = nxt_b[k];
               k++;
               if (k == 3) start = 1'b0;
            end
         end
         chk("b2b count", k, 32'd3);
         @(negedge clk);
         chk("idle after b2b", {30'd0, busy, done}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
